// File: rtl/pong_score_keeper.sv
// Pong score keeper: counts points from the game controller's win levels, holds the
// ball in a timed serve pause after each point, detects the match winner, drives 7-seg digits.
module pong_score_keeper #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 25000000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       new_game,
    output logic       round_rst,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [6:0] hex_p1,
    output logic [6:0] hex_p2,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] StServe = 2'd0;
    localparam logic [1:0] StPlay  = 2'd1;
    localparam logic [1:0] StOver  = 2'd2;

    localparam logic [CNT_W-1:0] CntReload = CNT_W'(SERVE_DELAY - 1);
    localparam logic [3:0]       WinVal    = 4'(WIN_SCORE);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       p1_q, p1_d, p2_q, p2_d;
    logic             round_rst_q, round_rst_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q, winner_d;
    logic             p1_win_q, p2_win_q, new_game_q;
    logic             p1_ev, p2_ev, ng_ev;

    assign p1_ev = p1_win & ~p1_win_q;
    assign p2_ev = p2_win & ~p2_win_q;
    assign ng_ev = new_game & ~new_game_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        round_rst_d = round_rst_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (ng_ev) begin
            state_d     = StServe;
            cnt_d       = CntReload;
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            round_rst_d = 1'b1;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
        end else begin
            case (state_q)
                StServe: begin
                    round_rst_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d     = StPlay;
                        round_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StPlay: begin
                    round_rst_d = 1'b0;
                    if (p1_ev || p2_ev) begin
                        // Both edges together means the point is replayed without scoring.
                        state_d     = StServe;
                        cnt_d       = CntReload;
                        round_rst_d = 1'b1;
                        if (p1_ev && !p2_ev) begin
                            p1_d = p1_q + 4'd1;
                            if (p1_d == WinVal) begin
                                state_d     = StOver;
                                game_over_d = 1'b1;
                                winner_d    = 2'b01;
                            end
                        end else if (p2_ev && !p1_ev) begin
                            p2_d = p2_q + 4'd1;
                            if (p2_d == WinVal) begin
                                state_d     = StOver;
                                game_over_d = 1'b1;
                                winner_d    = 2'b10;
                            end
                        end
                    end
                end
                StOver: begin
                    round_rst_d = 1'b1;
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d     = StServe;
                    cnt_d       = CntReload;
                    round_rst_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StServe;
            cnt_q       <= CntReload;
            p1_q        <= 4'd0;
            p2_q        <= 4'd0;
            round_rst_q <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            p1_win_q    <= 1'b0;
            p2_win_q    <= 1'b0;
            new_game_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            round_rst_q <= round_rst_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            p1_win_q    <= p1_win;
            p2_win_q    <= p2_win;
            new_game_q  <= new_game;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign round_rst = round_rst_q;
    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign hex_p1    = seg7(p1_q);
    assign hex_p2    = seg7(p2_q);

endmodule
